cms_axis_downsizer: RTL and testbench

AXI-Stream width downsizer placed directly downstream of the continuous monitoring system's 1024-bit master stream. It accepts one wide trace beat, holds it, and emits it as a sequence of narrower beats (default 256-bit) toward the DMA/FIFO path. Packet boundaries are preserved, and the stream runs at full narrow-beat throughput. It also keeps free-running beat and packet counters for software status readout.

---
 rtl/cms_axis_downsizer_pkg.sv | 20 ++
 rtl/cms_axis_downsizer.sv | 116 +++++++++++
 tb/tb_cms_axis_downsizer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cms_axis_downsizer_pkg.sv
// ============================================================================
// cms_axis_downsizer_pkg : shared widths and state encoding for the CMS downsizer
// Rev 1.0
// ============================================================================
`default_nettype none

package cms_axis_downsizer_pkg;

  localparam int AXI_DATA_WIDTH = 1024;
  localparam int DS_OUT_WIDTH   = 256;
  localparam int DS_CNT_WIDTH   = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ds_state_e;

endpackage

`default_nettype wire

// File: rtl/cms_axis_downsizer.sv
// ============================================================================
// cms_axis_downsizer : wide-to-narrow AXI-Stream splitter with beat/packet counters
// Rev 1.0
// ============================================================================
`default_nettype none

module cms_axis_downsizer
  import cms_axis_downsizer_pkg::*;
#(
  parameter int IN_WIDTH  = AXI_DATA_WIDTH,
  parameter int OUT_WIDTH = DS_OUT_WIDTH,
  parameter int CNT_WIDTH = DS_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [CNT_WIDTH-1:0] narrow_beats_sent,
  output logic [CNT_WIDTH-1:0] packets_sent
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("cms_axis_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end
  endgenerate

  ds_state_e                           r_state;
  logic [IDX_W-1:0]                    r_idx;
  logic [IN_WIDTH-1:0]                 r_hold;
  logic                                r_hold_last;
  logic [CNT_WIDTH-1:0]                r_beats;
  logic [CNT_WIDTH-1:0]                r_pkts;

  logic                                w_full;
  logic                                w_last_idx;
  logic                                w_m_hs;
  logic                                w_s_hs;
  logic [RATIO-1:0][OUT_WIDTH-1:0]     w_slices;

  assign w_full     = (r_state == ST_FULL);
  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_slices   = r_hold;

  // Refill is allowed on the cycle the final slice leaves, giving gap-free output.
  assign S_AXIS_tready = ~w_full | (M_AXIS_tready & w_last_idx);
  assign M_AXIS_tvalid = w_full;
  assign M_AXIS_tdata  = w_slices[r_idx];
  assign M_AXIS_tlast  = w_full & r_hold_last & w_last_idx;

  assign w_m_hs = w_full & M_AXIS_tready;
  assign w_s_hs = S_AXIS_tvalid & S_AXIS_tready;

  assign narrow_beats_sent = r_beats;
  assign packets_sent      = r_pkts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_idx       <= '0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_s_hs) begin
            r_hold      <= S_AXIS_tdata;
            r_hold_last <= S_AXIS_tlast;
            r_idx       <= '0;
            r_state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_m_hs) begin
            if (!w_last_idx) begin
              r_idx <= r_idx + IDX_W'(1);
            end else if (w_s_hs) begin
              r_hold      <= S_AXIS_tdata;
              r_hold_last <= S_AXIS_tlast;
              r_idx       <= '0;
            end else begin
              r_idx   <= '0;
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats <= '0;
      r_pkts  <= '0;
    end else if (w_m_hs) begin
      r_beats <= r_beats + CNT_WIDTH'(1);
      if (M_AXIS_tlast) begin
        r_pkts <= r_pkts + CNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cms_axis_downsizer.sv
// ============================================================================
// tb_cms_axis_downsizer : queue-model checked bench for the CMS AXI-Stream downsizer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cms_axis_downsizer;

  localparam int IW = 1024;
  localparam int OW = 256;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_tvalid;
  logic [IW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_tready;

  wire           s_tready,  w_s_tready;
  wire           m_tvalid,  w_m_tvalid;
  wire  [OW-1:0] m_tdata,   w_m_tdata;
  wire           m_tlast,   w_m_tlast;
  wire  [31:0]   beats, pkts;
  wire  [3:0]    w_beats, w_pkts;

  cms_axis_downsizer dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready), .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast),
    .narrow_beats_sent(beats), .packets_sent(pkts)
  );

  cms_axis_downsizer #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(w_s_tready), .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(w_m_tvalid), .M_AXIS_tready(m_tready), .M_AXIS_tdata(w_m_tdata), .M_AXIS_tlast(w_m_tlast),
    .narrow_beats_sent(w_beats), .packets_sent(w_pkts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc;
  int first_acc;
  int rdy_mode = 0;
  int rdy_ph   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: the stream is a FIFO of pending narrow beats; a wide beat may enter
  // only when nothing is pending or the sole pending beat is leaving now.
  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } nb_t;

  nb_t         mq[$];
  int unsigned m_beats = 0;
  int unsigned m_pkts  = 0;

  always @(negedge clk) begin
    logic exp_sr, exp_v;
    logic [3:0] lb, lp;
    if (!rst_n) begin
      mq.delete();
      m_beats = 0;
      m_pkts  = 0;
    end
    exp_sr = (mq.size() == 0) || (mq.size() == 1 && m_tready);
    exp_v  = (mq.size() != 0);
    lb = m_beats[3:0];
    lp = m_pkts[3:0];
    chk("s_tready", {255'b0, s_tready}, {255'b0, exp_sr});
    chk("s_tready_w", {255'b0, w_s_tready}, {255'b0, exp_sr});
    chk("m_tvalid", {255'b0, m_tvalid}, {255'b0, exp_v});
    chk("m_tvalid_w", {255'b0, w_m_tvalid}, {255'b0, exp_v});
    if (exp_v) begin
      chk("m_tdata", m_tdata, mq[0].d);
      chk("m_tdata_w", w_m_tdata, mq[0].d);
      chk("m_tlast", {255'b0, m_tlast}, {255'b0, mq[0].l});
    end else begin
      chk("m_tlast_idle", {255'b0, m_tlast}, 256'd0);
    end
    chk("beats", {224'b0, beats}, {224'b0, m_beats});
    chk("pkts", {224'b0, pkts}, {224'b0, m_pkts});
    chk("beats_w", {252'b0, w_beats}, {252'b0, lb});
    chk("pkts_w", {252'b0, w_pkts}, {252'b0, lp});
    if (rst_n) begin
      if (exp_v && m_tready) begin
        m_beats++;
        if (mq[0].l) m_pkts++;
        void'(mq.pop_front());
      end
      if (s_tvalid && exp_sr) begin
        for (int k = 0; k < R; k++) mq.push_back('{d: s_tdata[k*OW +: OW], l: s_tlast && (k == R-1)});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: begin
        m_tready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        rdy_ph++;
      end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    int  n;
    logic hs;
    n = 0;
    hs = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = s_tvalid && s_tready;
      if (hs) last_acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("send_timeout", 256'd0, 256'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_tvalid || mq.size() != 0) && n < 400);
    chk("drain_idle", {255'b0, m_tvalid}, 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_tvalid"}, {255'b0, m_tvalid}, 256'd0);
    chk({tag, "_tlast"}, {255'b0, m_tlast}, 256'd0);
    chk({tag, "_tdata"}, m_tdata, 256'd0);
    chk({tag, "_tready"}, {255'b0, s_tready}, 256'd1);
    chk({tag, "_beats"}, {224'b0, beats}, 256'd0);
    chk({tag, "_pkts"}, {224'b0, pkts}, 256'd0);
  endtask

  function automatic logic [IW-1:0] rnd_wide();
    logic [IW-1:0] v;
    for (int i = 0; i < IW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [255:0] exp_sl [4] = '{
    {4{64'h1111111111111111}}, {4{64'h2222222222222222}},
    {4{64'h3333333333333333}}, {4{64'h4444444444444444}}
  };

  initial begin
    logic [IW-1:0] pat;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    reset_literals("rst");
    @(posedge clk); #1;

    // Single patterned beat, continuous ready
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 4; w++) pat[k*256 + w*64 +: 64] = {16{4'(k+1)}};
    send(pat, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("single_valid", {255'b0, m_tvalid}, 256'd1);
      chk("single_data", m_tdata, exp_sl[k]);
      chk("single_last", {255'b0, m_tlast}, {255'b0, k == 3});
    end
    @(negedge clk);
    chk("single_beats", {224'b0, beats}, 256'd4);
    chk("single_pkts", {224'b0, pkts}, 256'd1);
    @(posedge clk); #1;

    // Back-to-back streaming: 8 wide beats, tlast on 4th and 8th
    for (int i = 0; i < 8; i++) begin
      send(rnd_wide(), (i == 3) || (i == 7));
      if (i == 0) first_acc = last_acc;
    end
    chk("b2b_accept_span", 256'(last_acc - first_acc), 256'd28);
    drain();
    chk("b2b_beats", {224'b0, beats}, 256'd36);
    chk("b2b_pkts", {224'b0, pkts}, 256'd3);

    // Backpressure with a 1,0,0,1 ready pattern
    rdy_mode = 1; rdy_ph = 0;
    send(rnd_wide(), 1'b0);
    send(rnd_wide(), 1'b1);
    drain();
    rdy_mode = 0;
    chk("bp_beats", {224'b0, beats}, 256'd44);
    chk("bp_pkts", {224'b0, pkts}, 256'd4);

    // Reset while a packet is half emitted
    @(posedge clk); #1;
    send(rnd_wide(), 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    reset_literals("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    drain();

    // Counter wrap in the 4-bit build
    for (int i = 0; i < 5; i++) send(rnd_wide(), i == 4);
    drain();
    chk("wrap_beats_w", {252'b0, w_beats}, 256'd4);
    chk("wrap_beats", {224'b0, beats}, 256'd20);
    chk("wrap_pkts_w", {252'b0, w_pkts}, 256'd1);

    // Random stress
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rnd_wide(), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
